// File: rtl/instruction_issuer.sv
// instruction_issuer: producer end of the 6-bit instruction interface.
// Loader words {opcode, flag} are buffered in a FIFO and issued one per
// non-stalled cycle while run is high; NOP filler is issued when idle or
// empty, and STORE_GAP NOP bubbles follow every STORE.
// Optional feature macro: ISSUE_COUNTER_EN adds a 16-bit issued_cnt output.
module instruction_issuer #(
    parameter int         DEPTH        = 8,
    parameter int         STORE_GAP    = 1,
    parameter logic [4:0] NOP_OPCODE   = 5'h00,
    parameter logic [4:0] STORE_OPCODE = 5'h01
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    input  logic [4:0]               wr_opcode,
    input  logic                     wr_flag,
    output logic                     wr_ready,
    input  logic                     run,
    input  logic                     stall,
    output logic [5:0]               instruction,
    output logic                     instr_valid,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     empty,
    output logic                     full
`ifdef ISSUE_COUNTER_EN
    ,
    output logic [15:0]              issued_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int GAP_W = (STORE_GAP < 2) ? 1 : $clog2(STORE_GAP + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_BUBBLE = 2'd2;

    localparam logic [5:0] NOP_WORD = {NOP_OPCODE, 1'b0};

    logic [5:0]       mem_q [DEPTH];
    logic [5:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [5:0]       instr_q, instr_d;
    logic             valid_q, valid_d;
    logic             do_write;
    logic             do_pop;
    logic [5:0]       head_word;
`ifdef ISSUE_COUNTER_EN
    logic [15:0]      issued_q, issued_d;
`endif

    assign full        = (count_q == CNT_W'(DEPTH));
    assign empty       = (count_q == '0);
    assign wr_ready    = !full;
    assign fifo_count  = count_q;
    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign head_word   = mem_q[rd_ptr_q];
    assign do_write    = wr_valid && !full;
    assign do_pop      = !stall && (state_q == ST_ISSUE) && run && !empty;
`ifdef ISSUE_COUNTER_EN
    assign issued_cnt  = issued_q;
`endif

    // Issue FSM: decides the next output word, bubble count and state; all of it freezes on stall.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (!stall) begin
            case (state_q)
                ST_IDLE: begin
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                    if (run) begin
                        state_d = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!run) begin
                        instr_d = NOP_WORD;
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                    end else if (!empty) begin
                        instr_d = head_word;
                        valid_d = 1'b1;
                        if ((STORE_GAP > 0) && (head_word[5:1] == STORE_OPCODE)) begin
                            gap_d   = GAP_W'(STORE_GAP);
                            state_d = ST_BUBBLE;
                        end
                    end else begin
                        instr_d = NOP_WORD;
                        valid_d = 1'b0;
                    end
                end
                ST_BUBBLE: begin
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                    gap_d   = gap_q - GAP_W'(1);
                    if (gap_q <= GAP_W'(1)) begin
                        gap_d   = '0;
                        state_d = run ? ST_ISSUE : ST_IDLE;
                    end
                end
                default: begin
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                    gap_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // FIFO bookkeeping: store accepted writes, advance pointers, track occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_write) begin
            mem_d[wr_ptr_q] = {wr_opcode, wr_flag};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_write) - CNT_W'(do_pop);
    end

`ifdef ISSUE_COUNTER_EN
    // Counts every FIFO word that reaches the output; wraps naturally at 16 bits.
    always_comb begin
        issued_d = issued_q;
        if (do_pop) begin
            issued_d = issued_q + 16'd1;
        end
    end
`endif

    // State registers; reset discards all buffered words and returns the output to NOP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= ST_IDLE;
            gap_q    <= '0;
            instr_q  <= NOP_WORD;
            valid_q  <= 1'b0;
`ifdef ISSUE_COUNTER_EN
            issued_q <= '0;
`endif
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            gap_q    <= gap_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
`ifdef ISSUE_COUNTER_EN
            issued_q <= issued_d;
`endif
        end
    end

endmodule

// File: tb/tb_instruction_issuer.sv
// Self-checking bench for instruction_issuer (DEPTH=4, STORE_GAP=2).
// A queue-based reference model predicts every output each cycle; directed
// scenarios are followed by a randomized phase and a mid-run reset.
module tb_instruction_issuer;

    localparam int         DEPTH     = 4;
    localparam int         STORE_GAP = 2;
    localparam logic [4:0] NOP_OP    = 5'h00;
    localparam logic [4:0] STORE_OP  = 5'h01;

    logic       clk;
    logic       rst;
    logic       wr_valid;
    logic [4:0] wr_opcode;
    logic       wr_flag;
    logic       wr_ready;
    logic       run;
    logic       stall;
    logic [5:0] instruction;
    logic       instr_valid;
    logic [2:0] fifo_count;
    logic       empty;
    logic       full;
`ifdef ISSUE_COUNTER_EN
    logic [15:0] issued_cnt;
`endif

    int tests_run;
    int tests_failed;

    // Reference model: plain queue plus "issuing enabled" and "bubbles left"
    logic [5:0] model_q [$];
    bit         model_active;
    int         model_gap;
    logic [5:0] exp_instr;
    logic       exp_valid;
    int         exp_issued;

    instruction_issuer #(
        .DEPTH(DEPTH),
        .STORE_GAP(STORE_GAP),
        .NOP_OPCODE(NOP_OP),
        .STORE_OPCODE(STORE_OP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_valid(wr_valid),
        .wr_opcode(wr_opcode),
        .wr_flag(wr_flag),
        .wr_ready(wr_ready),
        .run(run),
        .stall(stall),
        .instruction(instruction),
        .instr_valid(instr_valid),
        .fifo_count(fifo_count),
        .empty(empty),
        .full(full)
`ifdef ISSUE_COUNTER_EN
        ,
        .issued_cnt(issued_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        model_q.delete();
        model_active = 1'b0;
        model_gap    = 0;
        exp_instr    = {NOP_OP, 1'b0};
        exp_valid    = 1'b0;
        exp_issued   = 0;
    endtask

    // One clock edge of intended behaviour, using the inputs present at that edge
    task automatic modelStep();
        bit         accept;
        logic [5:0] w;
        if (rst) begin
            modelReset();
            return;
        end
        accept = wr_valid && (model_q.size() < DEPTH);
        if (!stall) begin
            if (model_gap > 0) begin
                exp_instr = {NOP_OP, 1'b0};
                exp_valid = 1'b0;
                model_gap--;
                if (model_gap == 0) model_active = run;
            end else if (!model_active || !run) begin
                exp_instr    = {NOP_OP, 1'b0};
                exp_valid    = 1'b0;
                model_active = run;
            end else if (model_q.size() > 0) begin
                w          = model_q.pop_front();
                exp_instr  = w;
                exp_valid  = 1'b1;
                exp_issued = (exp_issued + 1) % 65536;
                if (w[5:1] == STORE_OP) model_gap = STORE_GAP;
            end else begin
                exp_instr = {NOP_OP, 1'b0};
                exp_valid = 1'b0;
            end
        end
        if (accept) model_q.push_back({wr_opcode, wr_flag});
    endtask

    task automatic checkAll();
        checkOutput("instruction", 32'(instruction), 32'(exp_instr));
        checkOutput("instr_valid", 32'(instr_valid), 32'(exp_valid));
        checkOutput("fifo_count", 32'(fifo_count), 32'(model_q.size()));
        checkOutput("empty", 32'(empty), 32'(model_q.size() == 0));
        checkOutput("full", 32'(full), 32'(model_q.size() == DEPTH));
        checkOutput("wr_ready", 32'(wr_ready), 32'(model_q.size() != DEPTH));
`ifdef ISSUE_COUNTER_EN
        checkOutput("issued_cnt", 32'(issued_cnt), 32'(exp_issued));
`endif
    endtask

    // Drive one cycle of inputs, advance the model on the edge, check just after it
    task automatic applyStimulus(input logic wv, input logic [5:0] word, input logic r, input logic s);
        wr_valid  = wv;
        wr_opcode = word[5:1];
        wr_flag   = word[0];
        run       = r;
        stall     = s;
        @(posedge clk);
        modelStep();
        #1;
        checkAll();
    endtask

    initial begin
        logic [5:0] fill_words [5];
        tests_run    = 0;
        tests_failed = 0;
        fill_words   = '{6'h05, 6'h09, 6'h0D, 6'h11, 6'h15};
        wr_valid = 1'b0; wr_opcode = '0; wr_flag = 1'b0; run = 1'b0; stall = 1'b0;
        rst = 1'b1;
        modelReset();
        #1;
        checkAll();

        // Reset held for two cycles with run low
        applyStimulus(1'b0, 6'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 6'h00, 1'b0, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b0, 6'h00, 1'b0, 1'b0);

        // Fill: fifth word must be refused while full
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, fill_words[i], 1'b0, 1'b0);
        checkOutput("fill_count", 32'(fifo_count), 32'd4);
        checkOutput("fill_full", 32'(full), 32'd1);
        checkOutput("fill_ready", 32'(wr_ready), 32'd0);

        // Issue order with a 3-cycle stall while 0x09 is on the output
        applyStimulus(1'b0, 6'h00, 1'b1, 1'b0);
        checkOutput("start_nop", 32'(instruction), 32'h00);
        applyStimulus(1'b0, 6'h00, 1'b1, 1'b0);
        checkOutput("issue_05", 32'(instruction), 32'h05);
        applyStimulus(1'b0, 6'h00, 1'b1, 1'b0);
        checkOutput("issue_09", 32'(instruction), 32'h09);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 6'h00, 1'b1, 1'b1);
            checkOutput("stall_hold", 32'(instruction), 32'h09);
            checkOutput("stall_count", 32'(fifo_count), 32'd2);
        end
        applyStimulus(1'b0, 6'h00, 1'b1, 1'b0);
        checkOutput("issue_0d", 32'(instruction), 32'h0D);
        applyStimulus(1'b0, 6'h00, 1'b1, 1'b0);
        checkOutput("issue_11", 32'(instruction), 32'h11);
        applyStimulus(1'b0, 6'h00, 1'b1, 1'b0);
        checkOutput("drain_valid", 32'(instr_valid), 32'd0);
        checkOutput("drain_empty", 32'(empty), 32'd1);

        // STORE followed by two bubbles
        applyStimulus(1'b1, 6'h03, 1'b1, 1'b0);
        applyStimulus(1'b1, 6'h06, 1'b1, 1'b0);
        checkOutput("store_issue", 32'(instruction), 32'h03);
        applyStimulus(1'b0, 6'h00, 1'b1, 1'b0);
        checkOutput("bubble1", 32'(instr_valid), 32'd0);
        applyStimulus(1'b0, 6'h00, 1'b1, 1'b0);
        checkOutput("bubble2", 32'(instr_valid), 32'd0);
        applyStimulus(1'b0, 6'h00, 1'b1, 1'b0);
        checkOutput("after_bubble", 32'(instruction), 32'h06);

        // Randomized traffic with STOREs, stalls and run toggling
        for (int i = 0; i < 600; i++) begin
            logic [5:0] w;
            w = 6'($urandom);
            if ($urandom_range(0, 3) == 0) w[5:1] = STORE_OP;
            applyStimulus(1'($urandom_range(0, 9) < 6), w,
                          1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 3) == 0));
        end

        // Reset mid-run with three words queued and stall high
        applyStimulus(1'b0, 6'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 6'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 6'h00, 1'b0, 1'b0);
        while (model_q.size() > 0) applyStimulus(1'b0, 6'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 6'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 6'(8 + 2 * i), 1'b0, 1'b0);
        applyStimulus(1'b0, 6'h00, 1'b1, 1'b1);
        checkOutput("pre_reset_count", 32'(fifo_count), 32'd3);
        #3;
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("midrst_instr", 32'(instruction), 32'h00);
        checkOutput("midrst_valid", 32'(instr_valid), 32'd0);
        checkOutput("midrst_count", 32'(fifo_count), 32'd0);
`ifdef ISSUE_COUNTER_EN
        checkOutput("midrst_issued", 32'(issued_cnt), 32'd0);
`endif
        applyStimulus(1'b0, 6'h00, 1'b1, 1'b1);
        rst = 1'b0;
        applyStimulus(1'b0, 6'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 6'h00, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
